// File: rtl/spec_rat_ckpt.sv
// Speculative register alias table with a circular queue of full-table checkpoints.
// Recovery restores from a checkpoint or the committed map, then stalls rename while a walk replays.
module spec_rat_ckpt #(
  parameter int LREG_NUM = 32,
  parameter int PREG_W   = 6,
  parameter int RN_WIDTH = 2,
  parameter int CKPT_NUM = 4,
  localparam int LREG_W  = $clog2(LREG_NUM),
  localparam int CK_W    = $clog2(CKPT_NUM)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [RN_WIDTH-1:0]          rn_wren,
  input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrd,
  input  logic [RN_WIDTH*PREG_W-1:0]   rn_prd,
  input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs1,
  input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs2,
  output logic [RN_WIDTH*PREG_W-1:0]   rn_prs1,
  output logic [RN_WIDTH*PREG_W-1:0]   rn_prs2,
  output logic [RN_WIDTH*PREG_W-1:0]   rn_old_prd,
  input  logic                         ckpt_req,
  output logic [CK_W-1:0]              ckpt_id,
  output logic                         ckpt_avail,
  input  logic                         ckpt_release,
  input  logic                         recover_valid,
  input  logic [CK_W-1:0]              recover_id,
  input  logic                         flush_valid,
  input  logic [LREG_NUM*PREG_W-1:0]   arch_rat_flat,
  input  logic [RN_WIDTH-1:0]          walk_valid,
  input  logic [RN_WIDTH*LREG_W-1:0]   walk_lrd,
  input  logic [RN_WIDTH*PREG_W-1:0]   walk_prd,
  input  logic                         walk_done,
  output logic                         rn_stall,
  output logic [CK_W:0]                ckpt_count
);

  typedef enum logic {IDLE, WALK} state_e;

  state_e state_q, state_d;

  logic [PREG_W-1:0] table_q [LREG_NUM];
  logic [PREG_W-1:0] table_d [LREG_NUM];
  logic [PREG_W-1:0] rn_table [LREG_NUM];
  logic [PREG_W-1:0] walk_table [LREG_NUM];
  logic [PREG_W-1:0] arch_table [LREG_NUM];
  logic [PREG_W-1:0] ckpt_q [CKPT_NUM][LREG_NUM];
  logic [PREG_W-1:0] ckpt_d [CKPT_NUM][LREG_NUM];

  logic [CK_W-1:0] head_q, head_d;
  logic [CK_W-1:0] tail_q, tail_d;
  logic [CK_W:0]   count_q, count_d;

  logic [LREG_W-1:0] lrd_a [RN_WIDTH];
  logic [LREG_W-1:0] lrs1_a [RN_WIDTH];
  logic [LREG_W-1:0] lrs2_a [RN_WIDTH];
  logic [LREG_W-1:0] wlrd_a [RN_WIDTH];
  logic [PREG_W-1:0] prd_a [RN_WIDTH];
  logic [PREG_W-1:0] wprd_a [RN_WIDTH];

  logic [CK_W-1:0] rec_offset;
  logic            recover_hit;
  logic            alloc;
  logic            release_ok;
  logic            bypass_en;

  always_comb begin
    for (int j = 0; j < RN_WIDTH; j++) begin
      lrd_a[j]  = rn_lrd[j*LREG_W +: LREG_W];
      lrs1_a[j] = rn_lrs1[j*LREG_W +: LREG_W];
      lrs2_a[j] = rn_lrs2[j*LREG_W +: LREG_W];
      wlrd_a[j] = walk_lrd[j*LREG_W +: LREG_W];
      prd_a[j]  = rn_prd[j*PREG_W +: PREG_W];
      wprd_a[j] = walk_prd[j*PREG_W +: PREG_W];
    end
    for (int i = 0; i < LREG_NUM; i++) begin
      arch_table[i] = arch_rat_flat[i*PREG_W +: PREG_W];
    end
  end

  // Lookups see older same-cycle lanes only; iterating upward lets the youngest older writer win.
  assign bypass_en = (state_q == IDLE);

  always_comb begin
    rn_prs1    = '0;
    rn_prs2    = '0;
    rn_old_prd = '0;
    for (int j = 0; j < RN_WIDTH; j++) begin
      rn_prs1[j*PREG_W +: PREG_W]    = table_q[lrs1_a[j]];
      rn_prs2[j*PREG_W +: PREG_W]    = table_q[lrs2_a[j]];
      rn_old_prd[j*PREG_W +: PREG_W] = table_q[lrd_a[j]];
      for (int k = 0; k < RN_WIDTH; k++) begin
        if (k < j && bypass_en && rn_wren[k]) begin
          if (lrd_a[k] == lrs1_a[j]) rn_prs1[j*PREG_W +: PREG_W] = prd_a[k];
          if (lrd_a[k] == lrs2_a[j]) rn_prs2[j*PREG_W +: PREG_W] = prd_a[k];
          if (lrd_a[k] == lrd_a[j])  rn_old_prd[j*PREG_W +: PREG_W] = prd_a[k];
        end
      end
    end
  end

  always_comb begin
    rn_table   = table_q;
    walk_table = table_q;
    for (int j = 0; j < RN_WIDTH; j++) begin
      if (rn_wren[j])    rn_table[lrd_a[j]]    = prd_a[j];
      if (walk_valid[j]) walk_table[wlrd_a[j]] = wprd_a[j];
    end
  end

  // A slot is live when its distance from head falls inside the occupied count.
  assign rec_offset  = recover_id - head_q;
  assign recover_hit = recover_valid && ({1'b0, rec_offset} < count_q);
  assign ckpt_avail  = (count_q < (CK_W+1)'(CKPT_NUM));
  assign alloc       = ckpt_req && ckpt_avail && (state_q == IDLE);
  assign release_ok  = ckpt_release && (count_q != '0);

  always_comb begin
    table_d = table_q;
    ckpt_d  = ckpt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_valid) begin
      table_d = arch_table;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (recover_hit) begin
      table_d = ckpt_q[recover_id];
      tail_d  = recover_id + 1'b1;
      count_d = {1'b0, rec_offset} + 1'b1;
    end else begin
      table_d = (state_q == WALK) ? walk_table : rn_table;
      if (alloc) begin
        ckpt_d[tail_q] = rn_table;
        tail_d         = tail_q + 1'b1;
      end
      if (release_ok) head_d = head_q + 1'b1;
      case ({alloc, release_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LREG_NUM; i++) begin
        table_q[i] <= PREG_W'(i);
        for (int c = 0; c < CKPT_NUM; c++) ckpt_q[c][i] <= PREG_W'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      table_q <= table_d;
      ckpt_q  <= ckpt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_valid || recover_hit)       state_d = WALK;
    else if (state_q == WALK && walk_done) state_d = IDLE;
  end

  always_comb begin
    rn_stall   = (state_q == WALK);
    ckpt_id    = tail_q;
    ckpt_count = count_q;
  end

endmodule

// File: tb/tb_spec_rat_ckpt.sv
// Directed bench for spec_rat_ckpt: stimulus pushes hand-computed expectations into a
// scoreboard queue that a negedge monitor drains against the live outputs.
module tb_spec_rat_ckpt;

  localparam int LREG_NUM = 32;
  localparam int PREG_W   = 6;
  localparam int RN_WIDTH = 2;
  localparam int CKPT_NUM = 4;
  localparam int LREG_W   = 5;
  localparam int CK_W     = 2;

  logic                         clock;
  logic                         reset_n;
  logic [RN_WIDTH-1:0]          rn_wren;
  logic [RN_WIDTH*LREG_W-1:0]   rn_lrd;
  logic [RN_WIDTH*PREG_W-1:0]   rn_prd;
  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs1;
  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs2;
  logic [RN_WIDTH*PREG_W-1:0]   rn_prs1;
  logic [RN_WIDTH*PREG_W-1:0]   rn_prs2;
  logic [RN_WIDTH*PREG_W-1:0]   rn_old_prd;
  logic                         ckpt_req;
  logic [CK_W-1:0]              ckpt_id;
  logic                         ckpt_avail;
  logic                         ckpt_release;
  logic                         recover_valid;
  logic [CK_W-1:0]              recover_id;
  logic                         flush_valid;
  logic [LREG_NUM*PREG_W-1:0]   arch_rat_flat;
  logic [RN_WIDTH-1:0]          walk_valid;
  logic [RN_WIDTH*LREG_W-1:0]   walk_lrd;
  logic [RN_WIDTH*PREG_W-1:0]   walk_prd;
  logic                         walk_done;
  logic                         rn_stall;
  logic [CK_W:0]                ckpt_count;

  spec_rat_ckpt #(
    .LREG_NUM(LREG_NUM), .PREG_W(PREG_W), .RN_WIDTH(RN_WIDTH), .CKPT_NUM(CKPT_NUM)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .rn_wren(rn_wren), .rn_lrd(rn_lrd), .rn_prd(rn_prd),
    .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_old_prd(rn_old_prd),
    .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_avail(ckpt_avail),
    .ckpt_release(ckpt_release),
    .recover_valid(recover_valid), .recover_id(recover_id),
    .flush_valid(flush_valid), .arch_rat_flat(arch_rat_flat),
    .walk_valid(walk_valid), .walk_lrd(walk_lrd), .walk_prd(walk_prd), .walk_done(walk_done),
    .rn_stall(rn_stall), .ckpt_count(ckpt_count)
  );

  typedef enum int {S_PRS1, S_PRS2, S_OLD, S_ID, S_AVAIL, S_COUNT, S_STALL} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    int          lane;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] actual(sel_e s, int lane);
    case (s)
      S_PRS1:  return 32'(rn_prs1[lane*PREG_W +: PREG_W]);
      S_PRS2:  return 32'(rn_prs2[lane*PREG_W +: PREG_W]);
      S_OLD:   return 32'(rn_old_prd[lane*PREG_W +: PREG_W]);
      S_ID:    return 32'(ckpt_id);
      S_AVAIL: return 32'(ckpt_avail);
      S_COUNT: return 32'(ckpt_count);
      default: return 32'(rn_stall);
    endcase
  endfunction

  // Monitor: every negedge the outputs are settled for the current cycle's inputs.
  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = actual(e.sel, e.lane);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_out(input string name, input sel_e s, input int lane, input int exp);
    exp_t e;
    e.name = name;
    e.sel  = s;
    e.lane = lane;
    e.exp  = 32'(exp);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rn_wren       = '0;
    rn_lrd        = '0;
    rn_prd        = '0;
    rn_lrs1       = '0;
    rn_lrs2       = '0;
    ckpt_req      = 1'b0;
    ckpt_release  = 1'b0;
    recover_valid = 1'b0;
    recover_id    = '0;
    flush_valid   = 1'b0;
    walk_valid    = '0;
    walk_lrd      = '0;
    walk_prd      = '0;
    walk_done     = 1'b0;
  endtask

  task automatic set_rn(input int lane, input bit wren, input int lrd, input int prd,
                        input int lrs1, input int lrs2);
    rn_wren[lane]                  = wren;
    rn_lrd[lane*LREG_W +: LREG_W]  = LREG_W'(lrd);
    rn_prd[lane*PREG_W +: PREG_W]  = PREG_W'(prd);
    rn_lrs1[lane*LREG_W +: LREG_W] = LREG_W'(lrs1);
    rn_lrs2[lane*LREG_W +: LREG_W] = LREG_W'(lrs2);
  endtask

  task automatic set_walk(input int lane, input bit vld, input int lrd, input int prd);
    walk_valid[lane]                = vld;
    walk_lrd[lane*LREG_W +: LREG_W] = LREG_W'(lrd);
    walk_prd[lane*PREG_W +: PREG_W] = PREG_W'(prd);
  endtask

  // Lane 0 has no older lane, so its source ports read the table directly.
  task automatic check_table(input string name, input int port, input int lr, input int exp);
    if (port == 1) begin
      rn_lrs1[0 +: LREG_W] = LREG_W'(lr);
      expect_out(name, S_PRS1, 0, exp);
    end else begin
      rn_lrs2[0 +: LREG_W] = LREG_W'(lr);
      expect_out(name, S_PRS2, 0, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < LREG_NUM; i++) arch_rat_flat[i*PREG_W +: PREG_W] = PREG_W'(i);
    arch_rat_flat[7*PREG_W +: PREG_W] = PREG_W'(20);
    #1;
    check_table("reset_table4", 1, 4, 4);
    expect_out("reset_avail", S_AVAIL, 0, 1);
    expect_out("reset_id", S_ID, 0, 0);
    expect_out("reset_count", S_COUNT, 0, 0);
    expect_out("reset_stall", S_STALL, 0, 0);
    #11 reset_n = 1'b1;
    tick();

    // Two lanes writing the same logical register
    set_rn(0, 1, 5, 40, 5, 0);
    set_rn(1, 1, 5, 41, 5, 6);
    expect_out("bypass_prs1_l1", S_PRS1, 1, 40);
    expect_out("bypass_old_l1", S_OLD, 1, 40);
    expect_out("old_l0", S_OLD, 0, 5);
    expect_out("no_self_bypass_l0", S_PRS1, 0, 5);
    expect_out("prs2_l1", S_PRS2, 1, 6);
    tick();
    clear_inputs();

    // Checkpoint with a same-cycle rename write, then overwrite and recover
    set_rn(0, 1, 3, 33, 0, 0);
    ckpt_req = 1'b1;
    check_table("hi_lane_wins", 1, 5, 41);
    expect_out("ckpt_id_first", S_ID, 0, 0);
    expect_out("avail_first", S_AVAIL, 0, 1);
    tick();
    clear_inputs();
    set_rn(0, 1, 3, 50, 0, 0);
    set_rn(1, 0, 0, 0, 3, 0);
    expect_out("count_after_alloc", S_COUNT, 0, 1);
    expect_out("id_after_alloc", S_ID, 0, 1);
    expect_out("bypass_l1_r3", S_PRS1, 1, 50);
    tick();
    clear_inputs();
    recover_valid = 1'b1;
    recover_id    = 2'd0;
    ckpt_req      = 1'b1;
    set_rn(0, 1, 3, 60, 0, 0);
    check_table("table3_pre_recover", 1, 3, 50);
    tick();
    clear_inputs();
    set_rn(0, 1, 3, 7, 0, 0);
    set_rn(1, 0, 0, 0, 3, 0);
    ckpt_req  = 1'b1;
    walk_done = 1'b1;
    check_table("recover_table3", 1, 3, 33);
    check_table("recover_table5", 2, 5, 41);
    expect_out("recover_stall", S_STALL, 0, 1);
    expect_out("recover_count", S_COUNT, 0, 1);
    expect_out("recover_id_tail", S_ID, 0, 1);
    expect_out("walk_no_bypass", S_PRS1, 1, 33);
    tick();
    clear_inputs();
    ckpt_release = 1'b1;
    check_table("walk_ignores_rename", 1, 3, 33);
    expect_out("walk_done_idle", S_STALL, 0, 0);
    expect_out("walk_ckpt_req_ignored", S_COUNT, 0, 1);
    tick();
    expect_out("release_count", S_COUNT, 0, 0);
    expect_out("release_id", S_ID, 0, 1);
    tick();
    clear_inputs();
    expect_out("release_empty_ignored", S_COUNT, 0, 0);
    expect_out("release_empty_avail", S_AVAIL, 0, 1);

    // Reset pulse restores identity
    tick();
    reset_n = 1'b0;
    check_table("reset2_table5", 1, 5, 5);
    expect_out("reset2_id", S_ID, 0, 0);
    tick();
    reset_n  = 1'b1;
    ckpt_req = 1'b1;

    // Fill the checkpoint queue, overflow, release, alloc+release
    for (int i = 1; i <= CKPT_NUM; i++) begin
      tick();
      expect_out($sformatf("fill_count_%0d", i), S_COUNT, 0, i);
    end
    expect_out("full_avail", S_AVAIL, 0, 0);
    expect_out("full_id_wrap", S_ID, 0, 0);
    tick();
    expect_out("fifth_ignored", S_COUNT, 0, 4);
    ckpt_req     = 1'b0;
    ckpt_release = 1'b1;
    tick();
    expect_out("release_from_full", S_COUNT, 0, 3);
    expect_out("release_from_full_id", S_ID, 0, 0);
    expect_out("release_from_full_avail", S_AVAIL, 0, 1);
    ckpt_req = 1'b1;
    tick();
    clear_inputs();
    expect_out("alloc_release_count", S_COUNT, 0, 3);
    expect_out("alloc_release_id", S_ID, 0, 1);

    // Live slots are 2,3,0: slot 1 is stale, slot 3 is live
    recover_valid = 1'b1;
    recover_id    = 2'd1;
    tick();
    clear_inputs();
    expect_out("stale_recover_stall", S_STALL, 0, 0);
    expect_out("stale_recover_count", S_COUNT, 0, 3);
    recover_valid = 1'b1;
    recover_id    = 2'd3;
    tick();
    clear_inputs();
    expect_out("recover3_stall", S_STALL, 0, 1);
    expect_out("recover3_count", S_COUNT, 0, 2);
    expect_out("recover3_id", S_ID, 0, 0);
    flush_valid   = 1'b1;
    recover_valid = 1'b1;
    recover_id    = 2'd2;
    tick();
    clear_inputs();
    check_table("flush_table7", 1, 7, 20);
    expect_out("flush_count", S_COUNT, 0, 0);
    expect_out("flush_id", S_ID, 0, 0);
    expect_out("flush_stall", S_STALL, 0, 1);

    // Walk writes, then reset mid-walk
    set_walk(0, 1, 9, 12);
    set_walk(1, 1, 9, 13);
    tick();
    clear_inputs();
    check_table("walk_hi_lane", 1, 9, 13);
    expect_out("walk_stall", S_STALL, 0, 1);
    tick();
    clear_inputs();
    set_walk(0, 1, 9, 44);
    #2 reset_n = 1'b0;
    check_table("midwalk_reset_table9", 1, 9, 9);
    check_table("midwalk_reset_table7", 2, 7, 7);
    expect_out("midwalk_reset_stall", S_STALL, 0, 0);
    expect_out("midwalk_reset_count", S_COUNT, 0, 0);
    tick();
    reset_n = 1'b1;
    clear_inputs();
    tick();
    check_table("post_reset_table9", 1, 9, 9);
    expect_out("post_reset_stall", S_STALL, 0, 0);
    tick();
    tick();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
